// File: rtl/demux_1to8_dist_pkg.sv
// Shared constants and helpers for the 1-to-8 distributing demux.
package demux_1to8_dist_pkg;

    localparam int unsigned NumChan      = 8;
    localparam int unsigned SelW         = 3;
    localparam int unsigned CntW         = 4;
    localparam int unsigned DefaultWidth = 32;

    typedef logic [SelW-1:0]    chan_sel_t;
    typedef logic [NumChan-1:0] chan_mask_t;

    function automatic logic [CntW-1:0] popcount(input chan_mask_t v);
        logic [CntW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NumChan; i++) begin
            cnt = cnt + CntW'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel: holding register plus valid flag, where a write beats an ack.
module demux_chan_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             valid_nxt
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Exposed so the parent can register the occupancy count in the same edge.
    always_comb begin
        valid_nxt = wr | (valid_q & ~ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr) begin
                data_q <= d;
            end
            valid_q <= valid_nxt;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/demux_1to8_dist.sv
// Distributes input words to eight holding registers, chosen by sel or a round-robin pointer.
module demux_1to8_dist
    import demux_1to8_dist_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in,
    input  logic [2:0]       sel,
    input  logic             auto_mode,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_e,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_h,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ack,
    output logic [2:0]       rr_ptr,
    output logic [3:0]       pending
);

    chan_sel_t        tgt;
    chan_sel_t        rr_ptr_q;
    chan_mask_t       wr;
    chan_mask_t       valid_nxt;
    logic             accept;
    logic [CntW-1:0]  pending_q;
    logic [WIDTH-1:0] data [NumChan];

    always_comb begin
        tgt      = auto_mode ? rr_ptr_q : sel;
        in_ready = ~out_valid[tgt] | out_ack[tgt];
        accept   = in_valid & in_ready;
        wr       = '0;
        wr[tgt]  = accept;
    end

    for (genvar i = 0; i < NumChan; i++) begin : g_chan
        demux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr[i]),
            .ack      (out_ack[i]),
            .d        (d_in),
            .q        (data[i]),
            .valid    (out_valid[i]),
            .valid_nxt(valid_nxt[i])
        );
    end

    // Pointer only advances on auto-mode accepts; mode switches leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            if (accept && auto_mode) begin
                rr_ptr_q <= rr_ptr_q + 3'd1;
            end
            pending_q <= popcount(valid_nxt);
        end
    end

    assign rr_ptr  = rr_ptr_q;
    assign pending = pending_q;
    assign out_a   = data[0];
    assign out_b   = data[1];
    assign out_c   = data[2];
    assign out_d   = data[3];
    assign out_e   = data[4];
    assign out_f   = data[5];
    assign out_g   = data[6];
    assign out_h   = data[7];

endmodule

// File: tb/tb_demux_1to8_dist.sv
// Bench for demux_1to8_dist: directed scenarios plus random traffic against a channel model.
module tb_demux_1to8_dist;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] d_in;
    logic [2:0]  sel;
    logic        auto_mode;
    logic [31:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ack;
    logic [2:0]  rr_ptr;
    logic [3:0]  pending;
    logic [31:0] dout [8];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    logic [31:0] m_data  [8];
    bit          m_valid [8];
    int          m_ptr;

    always #5 clk = ~clk;

    demux_1to8_dist dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d_in     (d_in),
        .sel      (sel),
        .auto_mode(auto_mode),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_d    (out_d),
        .out_e    (out_e),
        .out_f    (out_f),
        .out_g    (out_g),
        .out_h    (out_h),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .rr_ptr   (rr_ptr),
        .pending  (pending)
    );

    assign dout[0] = out_a;
    assign dout[1] = out_b;
    assign dout[2] = out_c;
    assign dout[3] = out_d;
    assign dout[4] = out_e;
    assign dout[5] = out_f;
    assign dout[6] = out_g;
    assign dout[7] = out_h;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_mask();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    // Channel-level behaviour at a clock edge, from the currently applied inputs.
    task automatic model_step();
        int  t;
        bit  rdy;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_data[i]  = '0;
                m_valid[i] = 1'b0;
            end
            m_ptr = 0;
        end else begin
            t   = auto_mode ? m_ptr : int'(sel);
            rdy = !m_valid[t] || out_ack[t];
            for (int i = 0; i < 8; i++) if (out_ack[i]) m_valid[i] = 1'b0;
            if (in_valid && rdy) begin
                m_data[t]  = d_in;
                m_valid[t] = 1'b1;
                if (auto_mode) m_ptr = (m_ptr + 1) % 8;
            end
        end
    endtask

    task automatic set_in(input bit iv, input int s, input bit am, input logic [31:0] d,
                          input logic [7:0] ak, input bit r);
        in_valid  = iv;
        sel       = 3'(s);
        auto_mode = am;
        d_in      = d;
        out_ack   = ak;
        rst       = r;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        int t;
        if (check_en) begin
            t = auto_mode ? m_ptr : int'(sel);
            chk("in_ready", 64'(in_ready), 64'(!m_valid[t] || out_ack[t]));
            chk("out_valid", 64'(out_valid), 64'(m_mask()));
            chk("pending", 64'(pending), 64'(m_count()));
            chk("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
            for (int i = 0; i < 8; i++) chk($sformatf("data[%0d]", i), 64'(dout[i]), 64'(m_data[i]));
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
        m_ptr = 0;

        // Reset with traffic present: must come out empty and ready.
        set_in(1, 0, 0, 32'h1111, 8'hFF, 1);
        tick();
        tick();
        check_en = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'h0);
        chk("rst pending", 64'(pending), 64'h0);
        chk("rst rr_ptr", 64'(rr_ptr), 64'h0);
        chk("rst in_ready", 64'(in_ready), 64'h1);

        // Single manual accept to channel d.
        set_in(1, 3, 0, 32'hDEADBEEF, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("man out_d", 64'(out_d), 64'hDEADBEEF);
        chk("man out_valid", 64'(out_valid), 64'h08);
        chk("man pending", 64'(pending), 64'h1);
        chk("man out_a", 64'(out_a), 64'h0);

        // Full channel back-pressures for 5 cycles, then ack and write together.
        for (int k = 0; k < 5; k++) begin
            set_in(1, 3, 0, 32'h1234, 0, 0);
            #1;
            chk("full in_ready", 64'(in_ready), 64'h0);
            tick();
            chk("full out_d", 64'(out_d), 64'hDEADBEEF);
            chk("full pending", 64'(pending), 64'h1);
        end
        set_in(1, 3, 0, 32'h1234, 8'h08, 0);
        #1;
        chk("ackwr in_ready", 64'(in_ready), 64'h1);
        tick();
        chk("ackwr out_d", 64'(out_d), 64'h1234);
        chk("ackwr valid3", 64'(out_valid[3]), 64'h1);

        // Fill all eight, then drain in one edge.
        set_in(0, 0, 0, 0, 8'hFF, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            set_in(1, i, 0, 32'(100 + i), 0, 0);
            tick();
        end
        chk("fill pending", 64'(pending), 64'h8);
        chk("fill out_valid", 64'(out_valid), 64'hFF);
        set_in(0, 0, 0, 0, 8'hFF, 0);
        tick();
        chk("drain pending", 64'(pending), 64'h0);
        chk("drain out_valid", 64'(out_valid), 64'h0);
        chk("drain out_a", 64'(out_a), 64'd100);
        chk("drain out_h", 64'(out_h), 64'd107);

        // Auto mode: nine accepts with all acks held high.
        for (int i = 1; i <= 9; i++) begin
            set_in(1, 0, 1, 32'(i), 8'hFF, 0);
            #1;
            chk("auto rr_ptr seq", 64'(rr_ptr), 64'((i - 1) % 8));
            tick();
        end
        chk("auto out_a", 64'(out_a), 64'd9);
        for (int k = 1; k < 8; k++) chk("auto data", 64'(dout[k]), 64'(k + 1));
        chk("auto rr_ptr end", 64'(rr_ptr), 64'd1);
        set_in(0, 0, 0, 0, 8'hFF, 0);
        tick();
        chk("mode hold rr_ptr", 64'(rr_ptr), 64'd1);

        // Ack on empty channel g alongside an accept to channel c.
        set_in(1, 2, 0, 32'hC0FFEE, 8'h40, 0);
        tick();
        chk("ign out_valid", 64'(out_valid), 64'h04);
        chk("ign pending", 64'(pending), 64'h1);

        // Five channels full, then reset with an accept in flight.
        for (int i = 0; i < 5; i++) begin
            if (i != 2) begin
                set_in(1, i, 0, 32'(200 + i), 0, 0);
                tick();
            end
        end
        chk("pre-rst pending", 64'(pending), 64'h5);
        set_in(1, 5, 0, 32'h55, 8'hFF, 1);
        tick();
        chk("midrst out_valid", 64'(out_valid), 64'h0);
        chk("midrst pending", 64'(pending), 64'h0);
        chk("midrst rr_ptr", 64'(rr_ptr), 64'h0);
        chk("midrst out_f", 64'(out_f), 64'h0);
        chk("midrst out_a", 64'(out_a), 64'h0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(9) < 7), int'($urandom_range(7)), bit'($urandom_range(1)),
                   $urandom, 8'($urandom & $urandom), ($urandom_range(59) == 0));
            tick();
        end

        set_in(0, 0, 0, 0, 0, 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
